serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit unsigned adder: the multi-cycle sequential stage that consumes
//  the combinational half-adder cell, one result bit per clock. Each cycle's bit
//  slice is a full adder (two half-adder cells + OR) with a registered carry.
//  Sits between an operand producer (start/operand handshake) and a result consumer
//  (done pulse + held result). Trades latency for area vs. a parallel ripple adder.
// PARAMETERS
//  N   8   operand/result width in bits; legal range N >= 1
// PORTS
//  clk    in   1   single clock, all state updates on rising edge
//  rst    in   1   reset, asynchronous, active-high; clears all state
//  start  in   1   request; sampled only in IDLE
//  a      in   N   operand A, captured on accepted start
//  b      in   N   operand B, captured on accepted start
//  busy   out  1   high in ADD and DONE states
//  done   out  1   one-cycle pulse: sum/cout valid from this cycle
//  sum    out  N   result (a+b) mod 2^N, held until next accepted start
//  cout   out  1   carry out of bit N-1, held with sum
// BEHAVIOUR
//  Reset (async assert, any state): state=IDLE, shift regs=0, carry=0, count=0,
//   busy=0, done=0, sum=0, cout=0. Operation in flight is abandoned, no done pulse.
//  FSM states: IDLE, ADD, DONE.
//   IDLE: start=1 -> capture a,b into shift regs, carry<=0, count<=0, -> ADD.
//         start=0 -> stay. sum/cout keep last result.
//   ADD : per cycle: s = a_sr[0]^b_sr[0]^carry; carry <= majority(a_sr[0],b_sr[0],carry);
//         a_sr,b_sr shift right (MSB fill 0); s shifts into sum_sr MSB;
//         count <= count+1. After N ADD cycles (count==N-1 this cycle) -> DONE.
//   DONE: sum <= sum_sr, cout <= carry; done=1 for exactly this cycle; -> IDLE.
//  Latency: start sampled at edge 0 -> N ADD cycles -> done high in cycle N+1.
//   Next start accepted earliest in cycle N+2 (IDLE). Throughput 1 op / N+2 cycles.
//  start while busy (ADD or DONE): ignored, no effect on operands or result.
//  a/b changes after capture: no effect on the operation in flight.
//  sum/cout registered outputs; only update in DONE. done/busy decode from state.
//  Arithmetic: unsigned; {cout,sum} == a+b exactly (N+1-bit result).
//  count width = max(1,$clog2(N)); N=1: single ADD cycle, done in cycle 2.
//  No X propagation: all regs have reset values; start sampled as 0/1 only.
// TESTING
//  N=8: a=8'h0F,b=8'h01,start 1 cycle -> busy 1, done in cycle 9, sum=8'h10,cout=0.
//  N=8: a=8'hFF,b=8'h01 -> sum=8'h00,cout=1 (full carry ripple); 8'hFF+8'hFF -> FE,1.
//  N=8: start pulsed mid-ADD with a=8'hAA,b=8'h55 -> ignored; first op result unchanged,
//   then a fresh start in IDLE with same values -> sum=8'hFF,cout=0.
//  N=8: rst asserted in ADD cycle 4 -> all outputs 0 immediately, no done pulse;
//   after release, 8'h80+8'h80 -> sum=8'h00,cout=1.
//  N=8: back-to-back start held high -> ops accepted every 10 cycles, results held
//   stable between done pulses; operands changed during ADD do not alter result.
//  N=1: all four (a,b) combos -> {cout,sum} = 00,01,01,10, done in cycle 2.
//  Random: 1000 ops vs. reference a+b model; check done exactly one cycle wide.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit unsigned adder.
//
// Produces one result bit per clock, LSB first. Each cycle's bit slice is a full adder
// built from two half-adder cells plus an OR, with the carry held in a register between
// slices. This uses far less logic than a parallel ripple adder, at the cost of N+2
// cycles per operation.
//
// Parameters
//   N      operand/result width in bits (N >= 1)
//
// Ports
//   clk    clock; all state updates on the rising edge
//   rst    asynchronous active-high reset; clears all state and abandons any operation
//   start  request; only sampled while idle
//   a, b   operands; captured on an accepted start
//   busy   high while an operation is in flight (ADD or DONE)
//   done   one-cycle pulse; sum/cout are valid from this cycle on
//   sum    (a + b) mod 2^N; held until the next result is produced
//   cout   carry out of bit N-1; held with sum
module serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCount = CW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_sr_q, a_sr_d;
  logic [N-1:0]    b_sr_q, b_sr_d;
  logic [N-1:0]    sum_sr_q, sum_sr_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [CW-1:0]   count_q, count_d;

  // Half-adder cell: {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-adder bit slice for the current LSBs and the registered carry.
  logic [1:0] ha0, ha1;
  logic       fa_sum, fa_carry;

  always_comb begin
    ha0      = half_add(a_sr_q[0], b_sr_q[0]);
    ha1      = half_add(ha0[0], carry_q);
    fa_sum   = ha1[0];
    fa_carry = ha0[1] | ha1[1];
  end

  // Result shift register with the new bit entering at the MSB. After N slices the
  // first bit computed (bit 0) has reached the LSB.
  logic [N-1:0] sum_shift;

  if (N == 1) begin : g_w1
    assign sum_shift = fa_sum;
  end else begin : g_wn
    assign sum_shift = {fa_sum, sum_sr_q[N-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        if (start == 1'b1) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = 1'b0;
          count_d = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_carry;
        sum_sr_d = sum_shift;
        count_d  = count_q + CW'(1);
        if (count_q == LastCount) begin
          // Load the outputs on the edge that enters DONE, so sum/cout are
          // already valid during the done pulse.
          sum_d   = sum_shift;
          cout_d  = fa_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at N=8 and N=1.
// Expected {cout,sum} values are queued when an operation is launched and are
// compared when the matching done pulse appears; outputs are also checked to
// hold the last result in every other cycle.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_adder #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.N(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [8:0] exp8_q[$];
  int         acc8_q[$];
  logic [8:0] held8 = '0;
  logic       done8_prev = 1'b0;
  logic [1:0] exp1_q[$];
  int         acc1_q[$];
  logic [1:0] held1 = '0;
  logic       done1_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // N=8 monitor.
  always @(negedge clk) begin
    if (rst) begin
      held8 = '0;
    end else if (done8) begin
      if (exp8_q.size() == 0) begin
        chk("unexpected_done8", 32'(done8), 32'(0));
      end else begin
        held8 = exp8_q.pop_front();
        chk("latency8", 32'(cyc - acc8_q.pop_front()), 32'(8));
        chk("busy_in_done8", 32'(busy8), 32'(1));
      end
    end
    chk("result8", 32'({cout8, sum8}), 32'(held8));
    if (done8_prev) begin
      chk("done_width8", 32'(done8), 32'(0));
      chk("idle_after_done8", 32'(busy8), 32'(0));
    end
    done8_prev = done8;
  end

  // N=1 monitor.
  always @(negedge clk) begin
    if (rst) begin
      held1 = '0;
    end else if (done1) begin
      if (exp1_q.size() == 0) begin
        chk("unexpected_done1", 32'(done1), 32'(0));
      end else begin
        held1 = exp1_q.pop_front();
        chk("latency1", 32'(cyc - acc1_q.pop_front()), 32'(1));
        chk("busy_in_done1", 32'(busy1), 32'(1));
      end
    end
    chk("result1", 32'({cout1, sum1}), 32'(held1));
    if (done1_prev) begin
      chk("done_width1", 32'(done1), 32'(0));
      chk("idle_after_done1", 32'(busy1), 32'(0));
    end
    done1_prev = done1;
  end

  // Launch one operation from IDLE; scrambles operands once they are captured.
  task automatic launch8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start8 = 1'b1;
    a8     = x;
    b8     = y;
    exp8_q.push_back({1'b0, x} + {1'b0, y});
    acc8_q.push_back(cyc + 1);
    @(negedge clk);
    start8 = 1'b0;
    chk("busy_after_start8", 32'(busy8), 32'(1));
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic wait_done8;
    int n;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done8 !== 1'b1) chk("timeout8", 32'(done8), 32'(1));
  endtask

  task automatic launch1(input logic x, input logic y);
    @(negedge clk);
    start1 = 1'b1;
    a1     = x;
    b1     = y;
    exp1_q.push_back({1'b0, x} + {1'b0, y});
    acc1_q.push_back(cyc + 1);
    @(negedge clk);
    start1 = 1'b0;
    a1     = 1'($urandom);
    b1     = 1'($urandom);
  endtask

  task automatic wait_done1;
    int n;
    n = 0;
    while (done1 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done1 !== 1'b1) chk("timeout1", 32'(done1), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy8", 32'(busy8), 32'(0));
    chk("reset_done8", 32'(done8), 32'(0));
    chk("reset_busy1", 32'(busy1), 32'(0));
    rst = 1'b0;

    // Directed N=8 cases.
    launch8(8'h0F, 8'h01); wait_done8();
    launch8(8'hFF, 8'h01); wait_done8();
    launch8(8'hFF, 8'hFF); wait_done8();

    // start during ADD is ignored; then the same operands from IDLE.
    launch8(8'h3C, 8'h12);
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    a8     = 8'hAA;
    b8     = 8'h55;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    launch8(8'hAA, 8'h55); wait_done8();

    // Reset in ADD cycle 4 abandons the operation with no done pulse.
    launch8(8'h5A, 8'h33);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy8", 32'(busy8), 32'(0));
    chk("rst_done8", 32'(done8), 32'(0));
    chk("rst_sum8", 32'(sum8), 32'(0));
    chk("rst_cout8", 32'(cout8), 32'(0));
    exp8_q.delete();
    acc8_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    launch8(8'h80, 8'h80); wait_done8();

    // start held high: one accept every 10 cycles, operands scrambled during ADD.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start8 = 1'b1;
      a8     = 8'(8'h31 * (i + 1));
      b8     = 8'(8'hC7 + i);
      exp8_q.push_back({1'b0, a8} + {1'b0, b8});
      acc8_q.push_back(cyc + 1);
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      repeat (8) @(negedge clk);
      @(negedge clk);
      if (i == 2) start8 = 1'b0;
    end

    // Random N=8 operations.
    for (int i = 0; i < 1000; i++) begin
      launch8(8'($urandom), 8'($urandom));
      wait_done8();
    end

    // N=1: all four combinations, then random.
    for (int i = 0; i < 4; i++) begin
      launch1(1'(i >> 1), 1'(i));
      wait_done1();
    end
    for (int i = 0; i < 200; i++) begin
      launch1(1'($urandom), 1'($urandom));
      wait_done1();
    end

    repeat (4) @(negedge clk);
    chk("drain8", 32'(exp8_q.size()), 32'(0));
    chk("drain1", 32'(exp1_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
